// File: rtl/tl45_types.sv
// rtl/tl45_types.sv - shared types and constants for the TL45 pipeline
package tl45_types;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_ACK  = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] TL45_NOP        = 32'h0000_0000;
    localparam logic [3:0]  TL45_WB_SEL_ALL = 4'hF;

endpackage

// File: rtl/tl45_fetch.sv
// rtl/tl45_fetch.sv - TL45 instruction fetch stage with pipelined Wishbone master
module tl45_fetch
    import tl45_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = TL45_NOP
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pipe_stall,
    input  logic        i_pipe_flush,
    input  logic        i_new_pc,
    input  logic [31:0] i_pc,
    output logic [31:0] o_buf_pc,
    output logic [31:0] o_buf_inst,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [29:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_data,
    output logic        o_fetch_err
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         discard_q, discard_d;
    logic         cyc_q, cyc_d;
    logic         stb_q, stb_d;
    logic [29:0]  addr_q, addr_d;
    logic [31:0]  hold_q, hold_d;
    logic         err_q, err_d;
    logic [31:0]  buf_pc_q, buf_pc_d;
    logic [31:0]  buf_inst_q, buf_inst_d;

    logic [31:0]  redirect_pc;
    logic [31:0]  pc_next;
    logic         load;
    logic [31:0]  load_inst;

    assign redirect_pc = {i_pc[31:2], 2'b00};
    assign pc_next     = pc_q + 32'd4;

    // Fetch sequencing: request issue, response handling, hold and error recovery.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        addr_d    = addr_q;
        hold_d    = hold_q;
        err_d     = err_q;
        load      = 1'b0;
        load_inst = hold_q;

        case (state_q)
            S_REQ: begin
                if (!cyc_q) begin
                    // Idle cycle between requests: raise the strobe at the (possibly redirected) pc.
                    cyc_d  = 1'b1;
                    stb_d  = 1'b1;
                    addr_d = pc_q[31:2];
                    if (i_new_pc) begin
                        pc_d   = redirect_pc;
                        addr_d = redirect_pc[31:2];
                    end
                end else if (!i_wb_stall) begin
                    stb_d   = 1'b0;
                    state_d = S_ACK;
                    if (i_new_pc) begin
                        // Old address already went out; its response must be thrown away.
                        pc_d      = redirect_pc;
                        discard_d = 1'b1;
                    end
                end else if (i_new_pc) begin
                    pc_d   = redirect_pc;
                    addr_d = redirect_pc[31:2];
                end
            end
            S_ACK: begin
                if (i_wb_ack || i_wb_err) begin
                    cyc_d   = 1'b0;
                    state_d = S_REQ;
                    if (discard_q || i_new_pc) begin
                        discard_d = 1'b0;
                        if (i_new_pc) begin
                            pc_d = redirect_pc;
                        end
                    end else if (i_wb_err) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else if (!i_pipe_stall) begin
                        load      = 1'b1;
                        load_inst = i_wb_data;
                        pc_d      = pc_next;
                    end else begin
                        hold_d  = i_wb_data;
                        state_d = S_HOLD;
                    end
                end else if (i_new_pc) begin
                    pc_d      = redirect_pc;
                    discard_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (i_new_pc) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (!i_pipe_stall) begin
                    load    = 1'b1;
                    pc_d    = pc_next;
                    state_d = S_REQ;
                end
            end
            S_ERR: begin
                if (i_new_pc) begin
                    pc_d    = redirect_pc;
                    err_d   = 1'b0;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // Output buffer: flush/redirect bubble beats a load, a load beats the idle bubble, stall holds.
    always_comb begin
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        if (i_pipe_flush || i_new_pc) begin
            buf_inst_d = NOP_INST;
        end else if (load) begin
            buf_inst_d = load_inst;
            buf_pc_d   = pc_q;
        end else if (!i_pipe_stall) begin
            buf_inst_d = NOP_INST;
        end
    end

    // State and output registers with synchronous reset that overrides any bus activity.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            discard_q  <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            addr_q     <= 30'd0;
            hold_q     <= NOP_INST;
            err_q      <= 1'b0;
            buf_pc_q   <= 32'd0;
            buf_inst_q <= NOP_INST;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            addr_q     <= addr_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
        end
    end

    assign o_buf_pc    = buf_pc_q;
    assign o_buf_inst  = buf_inst_q;
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = stb_q;
    assign o_wb_we     = 1'b0;
    assign o_wb_addr   = addr_q;
    assign o_wb_data   = 32'd0;
    assign o_wb_sel    = TL45_WB_SEL_ALL;
    assign o_fetch_err = err_q;

endmodule

// File: tb/tb_tl45_fetch.sv
// tb/tb_tl45_fetch.sv - directed vector bench for tl45_fetch
module tb_tl45_fetch;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_pipe_stall = 1'b0;
    logic        i_pipe_flush = 1'b0;
    logic        i_new_pc = 1'b0;
    logic [31:0] i_pc = 32'd0;
    logic [31:0] o_buf_pc;
    logic [31:0] o_buf_inst;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [29:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        i_wb_ack = 1'b0;
    logic        i_wb_stall = 1'b0;
    logic        i_wb_err = 1'b0;
    logic [31:0] i_wb_data = 32'd0;
    logic        o_fetch_err;

    tl45_fetch #(.RESET_PC(32'h0), .NOP_INST(32'h0)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_pipe_stall(i_pipe_stall),
        .i_pipe_flush(i_pipe_flush),
        .i_new_pc    (i_new_pc),
        .i_pc        (i_pc),
        .o_buf_pc    (o_buf_pc),
        .o_buf_inst  (o_buf_inst),
        .o_wb_cyc    (o_wb_cyc),
        .o_wb_stb    (o_wb_stb),
        .o_wb_we     (o_wb_we),
        .o_wb_addr   (o_wb_addr),
        .o_wb_data   (o_wb_data),
        .o_wb_sel    (o_wb_sel),
        .i_wb_ack    (i_wb_ack),
        .i_wb_stall  (i_wb_stall),
        .i_wb_err    (i_wb_err),
        .i_wb_data   (i_wb_data),
        .o_fetch_err (o_fetch_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        rst;
        logic        pstall;
        logic        flush;
        logic        newpc;
        logic [31:0] ipc;
        logic        ack;
        logic        wstall;
        logic        err;
        logic [31:0] wdata;
        logic        cyc;
        logic        stb;
        logic [29:0] addr;
        logic [31:0] bpc;
        logic [31:0] binst;
        logic        ferr;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;

    function automatic vec_t mk(input logic rst, input logic pstall, input logic flush,
                                input logic newpc, input logic [31:0] ipc,
                                input logic ack, input logic wstall, input logic err,
                                input logic [31:0] wdata,
                                input logic cyc, input logic stb, input logic [29:0] addr,
                                input logic [31:0] bpc, input logic [31:0] binst,
                                input logic ferr);
        vec_t v;
        v.rst = rst; v.pstall = pstall; v.flush = flush; v.newpc = newpc; v.ipc = ipc;
        v.ack = ack; v.wstall = wstall; v.err = err; v.wdata = wdata;
        v.cyc = cyc; v.stb = stb; v.addr = addr; v.bpc = bpc; v.binst = binst; v.ferr = ferr;
        return v;
    endfunction

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s %s: got 0x%08h expected 0x%08h", tag, name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input string tag);
        i_reset      = v.rst;
        i_pipe_stall = v.pstall;
        i_pipe_flush = v.flush;
        i_new_pc     = v.newpc;
        i_pc         = v.ipc;
        i_wb_ack     = v.ack;
        i_wb_stall   = v.wstall;
        i_wb_err     = v.err;
        i_wb_data    = v.wdata;
        @(posedge i_clk);
        #1;
        n_vec++;
        chk(tag, "cyc",      {31'd0, o_wb_cyc},    {31'd0, v.cyc});
        chk(tag, "stb",      {31'd0, o_wb_stb},    {31'd0, v.stb});
        chk(tag, "addr",     {2'd0, o_wb_addr},    {2'd0, v.addr});
        chk(tag, "buf_pc",   o_buf_pc,             v.bpc);
        chk(tag, "buf_inst", o_buf_inst,           v.binst);
        chk(tag, "fetch_err",{31'd0, o_fetch_err}, {31'd0, v.ferr});
        chk(tag, "we",       {31'd0, o_wb_we},     32'd0);
        chk(tag, "sel",      {28'd0, o_wb_sel},    32'hF);
        chk(tag, "wdata",    o_wb_data,            32'd0);
    endtask

    vec_t tbl[45];

    initial begin
        // rst pst fl np ipc | ack wst err wdata | cyc stb addr bpc binst ferr
        tbl[0]  = mk(1,0,0,0,0,           0,0,0,0,          0,0,30'h0,0,0,0);
        // zero-wait slave, mem[a] = a*16+1
        tbl[1]  = mk(0,0,0,0,0,           0,0,0,0,          1,1,30'h0,0,0,0);
        tbl[2]  = mk(0,0,0,0,0,           0,0,0,0,          1,0,30'h0,0,0,0);
        tbl[3]  = mk(0,0,0,0,0,           1,0,0,32'h1,      0,0,30'h0,0,32'h1,0);
        tbl[4]  = mk(0,0,0,0,0,           0,0,0,0,          1,1,30'h1,0,0,0);
        tbl[5]  = mk(0,0,0,0,0,           0,0,0,0,          1,0,30'h1,0,0,0);
        tbl[6]  = mk(0,0,0,0,0,           1,0,0,32'h11,     0,0,30'h1,4,32'h11,0);
        tbl[7]  = mk(0,0,0,0,0,           0,0,0,0,          1,1,30'h2,4,0,0);
        tbl[8]  = mk(0,0,0,0,0,           0,0,0,0,          1,0,30'h2,4,0,0);
        tbl[9]  = mk(0,0,0,0,0,           1,0,0,32'h21,     0,0,30'h2,8,32'h21,0);
        // bus stall: strobe and address stable, one ack consumed
        tbl[10] = mk(0,0,0,0,0,           0,0,0,0,          1,1,30'h3,8,0,0);
        tbl[11] = mk(0,0,0,0,0,           0,1,0,0,          1,1,30'h3,8,0,0);
        tbl[12] = mk(0,0,0,0,0,           0,1,0,0,          1,1,30'h3,8,0,0);
        tbl[13] = mk(0,0,0,0,0,           0,1,0,0,          1,1,30'h3,8,0,0);
        tbl[14] = mk(0,0,0,0,0,           0,0,0,0,          1,0,30'h3,8,0,0);
        tbl[15] = mk(0,0,0,0,0,           1,0,0,32'h31,     0,0,30'h3,32'hC,32'h31,0);
        // decode stall across an ack: hold path
        tbl[16] = mk(0,1,0,0,0,           0,0,0,0,          1,1,30'h4,32'hC,32'h31,0);
        tbl[17] = mk(0,1,0,0,0,           0,0,0,0,          1,0,30'h4,32'hC,32'h31,0);
        tbl[18] = mk(0,1,0,0,0,           1,0,0,32'hDEAD,   0,0,30'h4,32'hC,32'h31,0);
        tbl[19] = mk(0,1,0,0,0,           0,0,0,0,          0,0,30'h4,32'hC,32'h31,0);
        tbl[20] = mk(0,0,0,0,0,           0,0,0,0,          0,0,30'h4,32'h10,32'hDEAD,0);
        tbl[21] = mk(0,0,0,0,0,           0,0,0,0,          1,1,30'h5,32'h10,0,0);
        // redirect while waiting for ack
        tbl[22] = mk(0,0,0,0,0,           0,0,0,0,          1,0,30'h5,32'h10,0,0);
        tbl[23] = mk(0,0,0,1,32'h103,     0,0,0,0,          1,0,30'h5,32'h10,0,0);
        tbl[24] = mk(0,0,0,0,0,           1,0,0,32'hBAD,    0,0,30'h5,32'h10,0,0);
        tbl[25] = mk(0,0,0,0,0,           0,0,0,0,          1,1,30'h40,32'h10,0,0);
        tbl[26] = mk(0,0,0,0,0,           0,0,0,0,          1,0,30'h40,32'h10,0,0);
        tbl[27] = mk(0,0,0,0,0,           1,0,0,32'h77,     0,0,30'h40,32'h100,32'h77,0);
        // flush beats stall
        tbl[28] = mk(0,1,1,0,0,           0,0,0,0,          1,1,30'h41,32'h100,0,0);
        // redirect on the accepting edge
        tbl[29] = mk(0,0,0,1,32'h200,     0,0,0,0,          1,0,30'h41,32'h100,0,0);
        tbl[30] = mk(0,0,0,0,0,           1,0,0,32'hBAD,    0,0,30'h41,32'h100,0,0);
        tbl[31] = mk(0,0,0,0,0,           0,0,0,0,          1,1,30'h80,32'h100,0,0);
        // redirect while bus stalled: address moves, strobe stays
        tbl[32] = mk(0,0,0,1,32'h300,     0,1,0,0,          1,1,30'hC0,32'h100,0,0);
        tbl[33] = mk(0,0,0,0,0,           0,0,0,0,          1,0,30'hC0,32'h100,0,0);
        tbl[34] = mk(0,0,0,0,0,           1,0,0,32'h55,     0,0,30'hC0,32'h300,32'h55,0);
        // redirect coincident with ack: no discard left behind
        tbl[35] = mk(0,0,0,0,0,           0,0,0,0,          1,1,30'hC1,32'h300,0,0);
        tbl[36] = mk(0,0,0,0,0,           0,0,0,0,          1,0,30'hC1,32'h300,0,0);
        tbl[37] = mk(0,0,0,1,32'h400,     1,0,0,32'hBAD,    0,0,30'hC1,32'h300,0,0);
        tbl[38] = mk(0,0,0,0,0,           0,0,0,0,          1,1,30'h100,32'h300,0,0);
        tbl[39] = mk(0,0,0,0,0,           0,0,0,0,          1,0,30'h100,32'h300,0,0);
        tbl[40] = mk(0,0,0,0,0,           1,0,0,32'h66,     0,0,30'h100,32'h400,32'h66,0);
        // pc wraps from the top word to zero
        tbl[41] = mk(0,0,0,1,32'hFFFFFFFC,0,0,0,0,          1,1,30'h3FFFFFFF,32'h400,0,0);
        tbl[42] = mk(0,0,0,0,0,           0,0,0,0,          1,0,30'h3FFFFFFF,32'h400,0,0);
        tbl[43] = mk(0,0,0,0,0,           1,0,0,32'h99,     0,0,30'h3FFFFFFF,32'hFFFFFFFC,32'h99,0);
        tbl[44] = mk(0,0,0,0,0,           0,0,0,0,          1,1,30'h0,32'hFFFFFFFC,0,0);

        @(negedge i_clk);
        for (int i = 0; i < 45; i++) begin
            run(tbl[i], $sformatf("vec%0d", i));
        end

        // bus error on the first fetch after reset, then recovery by redirect
        run(mk(1,0,0,0,0,         0,0,0,0,        0,0,30'h0,0,0,0), "err_rst");
        run(mk(0,0,0,0,0,         0,0,0,0,        1,1,30'h0,0,0,0), "err_req");
        run(mk(0,0,0,0,0,         0,0,0,0,        1,0,30'h0,0,0,0), "err_acc");
        run(mk(0,0,0,0,0,         0,0,1,32'hBAD,  0,0,30'h0,0,0,1), "err_hit");
        for (int i = 0; i < 10; i++) begin
            run(mk(0,0,0,0,0,     0,0,0,0,        0,0,30'h0,0,0,1), $sformatf("err_idle%0d", i));
        end
        run(mk(0,0,0,1,32'h20,    0,0,0,0,        0,0,30'h0,0,0,0), "err_redir");
        run(mk(0,0,0,0,0,         0,0,0,0,        1,1,30'h8,0,0,0), "err_restart");

        // reset in the middle of a bus cycle, followed by a late ack
        run(mk(0,0,0,1,32'h40,    0,1,0,0,        1,1,30'h10,0,0,0), "rst_redir");
        run(mk(0,0,0,0,0,         0,0,0,0,        1,0,30'h10,0,0,0), "rst_acc");
        run(mk(1,0,0,0,0,         0,0,0,0,        0,0,30'h0,0,0,0), "rst_mid");
        run(mk(0,0,0,0,0,         1,0,0,32'hBAD,  1,1,30'h0,0,0,0), "rst_late_ack");
        run(mk(0,0,0,0,0,         0,0,0,0,        1,0,30'h0,0,0,0), "rst_acc2");
        run(mk(0,0,0,0,0,         1,0,0,32'h1,    0,0,30'h0,0,32'h1,0), "rst_fetch0");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
